wdt_multi: RTL

WDT_MULTI -- requirements
Module: wdt_multi

---
 rtl/wdt_multi_if.sv | 25 ++
 rtl/wdt_multi.sv | 132 +++++++++++++
 2 files changed

// File: rtl/wdt_multi_if.sv
// Bus bundle for wdt_multi: per-channel enables, pets, clears and fault outputs
// plus the shared timeout/window counts.
interface wdt_multi_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32
);
   logic [N_CH-1:0]   en;
   logic [N_CH-1:0]   pet;
   logic [CNT_W-1:0]  timeout_cnt;
   logic [CNT_W-1:0]  window_cnt;
   logic [N_CH-1:0]   irq_clr;
   logic [N_CH-1:0]   irq;
   logic              irq_any;
   logic [2*N_CH-1:0] cause;

   modport master (
      output en, pet, timeout_cnt, window_cnt, irq_clr,
      input  irq, irq_any, cause
   );

   modport slave (
      input  en, pet, timeout_cnt, window_cnt, irq_clr,
      output irq, irq_any, cause
   );
endinterface

// File: rtl/wdt_multi.sv
// Multi-channel watchdog: N_CH independent IDLE/RUN/FAULT channels sharing one timeout.
// Define WDT_MULTI_WINDOW_EN to fault on pets that arrive before window_cnt.
module wdt_multi #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       resetn,
   wdt_multi_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [N_CH-1:0]   pet_q_reg;
   logic [N_CH-1:0]   irq_vec;
   logic [2*N_CH-1:0] cause_vec;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pet_q_reg <= '0;
      end else begin
         pet_q_reg <= bus.pet;
      end
   end

`ifndef WDT_MULTI_WINDOW_EN
   logic unused_window;
   assign unused_window = ^bus.window_cnt;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         state_t           state_reg, state_next;
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic             irq_reg, irq_next;
         logic             to_reg, to_next;
         logic             early_reg, early_next;
         logic             pet_edge;
         logic             early_pet;
         logic             terminal;

         assign pet_edge = bus.pet[gi] & ~pet_q_reg[gi];
`ifdef WDT_MULTI_WINDOW_EN
         assign early_pet = pet_edge && (cnt_reg < bus.window_cnt);
`else
         assign early_pet = 1'b0;
`endif
         // A zero timeout disables the terminal compare so the counter just wraps.
         assign terminal = (bus.timeout_cnt != '0) && (cnt_reg == bus.timeout_cnt - ONE);

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               irq_reg   <= 1'b0;
               to_reg    <= 1'b0;
               early_reg <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               irq_reg   <= irq_next;
               to_reg    <= to_next;
               early_reg <= early_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            irq_next   = irq_reg;
            to_next    = to_reg;
            early_next = early_reg;
            case (state_reg)
               IDLE: begin
                  cnt_next = '0;
                  if (bus.en[gi]) begin
                     state_next = RUN;
                  end
               end
               RUN: begin
                  if (!bus.en[gi]) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else if (early_pet) begin
                     state_next = FAULT;
                     irq_next   = 1'b1;
                     early_next = 1'b1;
                  end else if (pet_edge) begin
                     // A valid pet beats a coincident terminal count.
                     cnt_next = '0;
                  end else if (terminal) begin
                     state_next = FAULT;
                     irq_next   = 1'b1;
                     to_next    = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + ONE;
                  end
               end
               FAULT: begin
                  if (bus.irq_clr[gi]) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                     irq_next   = 1'b0;
                     to_next    = 1'b0;
                     early_next = 1'b0;
                  end
               end
               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            endcase
         end

         assign irq_vec[gi]        = irq_reg;
         assign cause_vec[2*gi]    = to_reg;
         assign cause_vec[2*gi+1]  = early_reg;
      end
   endgenerate

   assign bus.irq     = irq_vec;
   assign bus.cause   = cause_vec;
   assign bus.irq_any = |irq_vec;

endmodule
